mdu_sequencer: RTL and testbench

//  Multi-cycle RV32M multiply/divide sequencer beside the main ALU. Accepts one op from decode
//  (ALUOp=2'b10, Funct7=7'b0000001) and runs a radix-2 shift-add / restoring-divide loop.

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_step.sv | 52 +++++
 rtl/mdu_sequencer.sv | 149 ++++++++++++++
 tb/tb_mdu_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the RV32M multiply/divide sequencer.
// Divide support is built only when MDU_DIV_EN is defined.
package mdu_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [1:0] ALUOP_MULDIV  = 2'b10;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  function automatic logic op_signed_a(mdu_op_e op);
    return !(op inside {OP_MULHU, OP_DIVU, OP_REMU});
  endfunction

  function automatic logic op_signed_b(mdu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// Divide path present only when MDU_DIV_EN is defined.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] quot_nxt
);

  logic [WIDTH:0] sum;
`ifdef MDU_DIV_EN
  logic [WIDTH:0] shl;
  logic [WIDTH:0] diff;
`else
  logic unused_mode;
  assign unused_mode = div_mode;
`endif

  always_comb begin
    // {acc,quot} is the product shifting right; quot[0] is the live multiplier bit
    sum      = {1'b0, acc} + (quot[0] ? {1'b0, dvs} : '0);
    acc_nxt  = sum[WIDTH:1];
    quot_nxt = {sum[0], quot[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    shl  = {acc, quot[WIDTH-1]};
    diff = shl - {1'b0, dvs};
    if (div_mode) begin
      if (!diff[WIDTH]) begin
        acc_nxt  = diff[WIDTH-1:0];
        quot_nxt = {quot[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt  = shl[WIDTH-1:0];
        quot_nxt = {quot[WIDTH-2:0], 1'b0};
      end
    end
`else
    shl_unused_guard();
`endif
  end

`ifndef MDU_DIV_EN
  function automatic void shl_unused_guard();
  endfunction
`endif

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer with pipeline stall.
// Define MDU_DIV_EN to build the divider; otherwise divides flag illegal.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  localparam int CNT_W = $clog2(WIDTH);

  mdu_state_e state_q, state_d;
  mdu_op_e op_in, op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, quot_q, dvs_q, res_q;
  logic [WIDTH-1:0] acc_nxt, quot_nxt;
  logic [WIDTH-1:0] mag_a, mag_b, fast_res, fin;
  logic [2*WIDTH-1:0] prod;
  logic sgn_a, sgn_b, neg_q;
  logic accept, fast, last;

  assign op_in  = mdu_op_e'(funct3);
  assign sgn_a  = op_signed_a(op_in) & operand_a[WIDTH-1];
  assign sgn_b  = op_signed_b(op_in) & operand_b[WIDTH-1];
  assign mag_a  = sgn_a ? -operand_a : operand_a;
  assign mag_b  = sgn_b ? -operand_b : operand_b;
  assign accept = start & ~flush & (state_q == IDLE);
  assign last   = cnt_q == CNT_W'(WIDTH - 1);
  assign result = res_q;

`ifdef MDU_DIV_EN
  logic negr_q, b_zero, ovf;
  assign b_zero = operand_b == '0;
  assign ovf    = ~funct3[0]
                & (operand_a == {1'b1, {(WIDTH-1){1'b0}}})
                & (&operand_b);
  assign fast   = funct3[2] & (b_zero | ovf);

  always_comb begin
    fast_res = '0;
    if (b_zero) fast_res = funct3[1] ? operand_a : '1;
    else if (!funct3[1]) fast_res = operand_a;
  end
`else
  logic ill_q;
  assign fast     = funct3[2];
  assign fast_res = '0;
`endif

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (op_q[2]),
    .acc      (acc_q),
    .quot     (quot_q),
    .dvs      (dvs_q),
    .acc_nxt  (acc_nxt),
    .quot_nxt (quot_nxt)
  );

  // Sign fix-up applied to the final iteration's output
  always_comb begin
    prod = neg_q ? -{acc_nxt, quot_nxt} : {acc_nxt, quot_nxt};
    fin  = prod[2*WIDTH-1:WIDTH];
    unique case (op_q)
      OP_MUL: fin = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
      OP_DIV, OP_DIVU: fin = neg_q ? -quot_nxt : quot_nxt;
      OP_REM, OP_REMU: fin = negr_q ? -acc_nxt : acc_nxt;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = fast ? DONE : CALC;
      CALC: begin
        if (flush)     state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = state_q != IDLE;
    stall = (start && state_q == IDLE) || state_q == CALC;
    done  = state_q == DONE;
`ifdef MDU_DIV_EN
    illegal = 1'b0;
`else
    illegal = (state_q == DONE) & ill_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= OP_MUL;
      cnt_q  <= '0;
      acc_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
      res_q  <= '0;
      neg_q  <= 1'b0;
`ifdef MDU_DIV_EN
      negr_q <= 1'b0;
`else
      ill_q  <= 1'b0;
`endif
    end else if (accept) begin
      op_q   <= op_in;
      cnt_q  <= '0;
      acc_q  <= '0;
      quot_q <= funct3[2] ? mag_a : mag_b;
      dvs_q  <= funct3[2] ? mag_b : mag_a;
      neg_q  <= sgn_a ^ sgn_b;
`ifdef MDU_DIV_EN
      negr_q <= sgn_a;
`else
      ill_q  <= funct3[2];
`endif
      if (fast) res_q <= fast_res;
    end else if (state_q == CALC && !flush) begin
      cnt_q  <= cnt_q + CNT_W'(1);
      acc_q  <= acc_nxt;
      quot_q <= quot_nxt;
      if (last) res_q <= fin;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: spec vectors, corner sequences,
// and random ops against an arithmetic reference model.
module tb_mdu_sequencer;
  import mdu_pkg::*;

`ifdef MDU_DIV_EN
  localparam bit DE = 1'b1;
`else
  localparam bit DE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  funct3;
  logic [31:0] operand_a, operand_b;
  logic        busy, stall, done, illegal;
  logic [31:0] result;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] last_exp;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    bit          ill;
    int          lat;
  } vec_t;
  vec_t tv[$];

  mdu_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .funct3    (funct3),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .result    (result),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic ref_op(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] r,
                        output bit ill, output int lat);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    ill = 1'b0;
    lat = 33;
    p = '0;
    case (f)
      3'd0, 3'd1: p = sa * sb;
      3'd2:       p = sa * longint'(ub);
      3'd3:       p = ua * ub;
      default: begin
        if (!DE) begin
          ill = 1'b1;
          lat = 1;
        end else if (b == 0) begin
          lat = 1;
          p = f[1] ? ua : 64'hFFFF_FFFF;
        end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lat = 1;
          p = f[1] ? 64'd0 : ua;
        end else begin
          case (f)
            3'd4:    p = sa / sb;
            3'd5:    p = ua / ub;
            3'd6:    p = sa % sb;
            default: p = ua % ub;
          endcase
        end
      end
    endcase
    r = (f == 3'd1 || f == 3'd2 || f == 3'd3) ? p[63:32] : p[31:0];
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic add(input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] r,
                     input bit ill, input int lat);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.r = r; v.ill = ill; v.lat = lat;
    tv.push_back(v);
  endtask

  // Drive start for cycle 0; returns at cycle 1 with inputs scrambled
  task automatic issue(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    funct3 = f;
    operand_a = a;
    operand_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    funct3 = 3'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  task automatic run_op(input string nm, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input bit eill,
                        input int elat);
    int lat;
    bit bad;
    logic ill_seen;
    @(negedge clk);
    start = 1'b1;
    funct3 = f;
    operand_a = a;
    operand_b = b;
    #1;
    chk({nm, "/stall0"}, 64'(stall), 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    funct3 = 3'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
    lat = 0;
    bad = 1'b0;
    ill_seen = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        lat = c;
        ill_seen = illegal;
        break;
      end
      if (!busy || !stall) bad = 1'b1;
      @(posedge clk);
      #1;
    end
    chk({nm, "/latency"}, 64'(lat), 64'(elat));
    chk({nm, "/result"}, 64'(result), 64'(er));
    chk({nm, "/illegal"}, 64'(ill_seen), 64'(eill));
    chk({nm, "/busy_stall"}, 64'(bad), 64'd0);
    @(posedge clk);
    #1;
    chk({nm, "/pulse"}, 64'({done, busy}), 64'd0);
    last_exp = er;
  endtask

  initial begin
    logic [31:0] er, a, b;
    logic [2:0] f;
    bit eill, seen;
    int elat;
    logic [3:0] pat;

    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    funct3 = '0;
    operand_a = '0;
    operand_b = '0;
    last_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 64'({busy, stall, done, illegal, result}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    add(OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 33);
    add(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 33);
    add(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 33);
    add(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 0, 33);
    add(OP_MUL,    32'd0,         32'd12345,     32'd0,         0, 33);
    add(OP_DIV,  32'hFFFF_FFEC, 32'd3,
        DE ? 32'hFFFF_FFFA : 32'd0, !DE, DE ? 33 : 1);
    add(OP_REM,  32'hFFFF_FFEC, 32'd3,
        DE ? 32'hFFFF_FFFE : 32'd0, !DE, DE ? 33 : 1);
    add(OP_DIVU, 32'd100, 32'd7, DE ? 32'd14 : 32'd0, !DE, DE ? 33 : 1);
    add(OP_DIV,  32'd5, 32'd0, DE ? 32'hFFFF_FFFF : 32'd0, !DE, 1);
    add(OP_REM,  32'd5, 32'd0, DE ? 32'd5 : 32'd0, !DE, 1);
    add(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF,
        DE ? 32'h8000_0000 : 32'd0, !DE, 1);
    add(OP_DIVU, 32'd9, 32'd3, DE ? 32'd3 : 32'd0, !DE, DE ? 33 : 1);

    for (int i = 0; i < tv.size(); i++)
      run_op($sformatf("vec%0d", i), tv[i].f, tv[i].a, tv[i].b,
             tv[i].r, tv[i].ill, tv[i].lat);

    // Flush during CALC: back to IDLE, no done, result kept
    issue(OP_MUL, 32'd11, 32'd13);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_idle", 64'(busy), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("flush_nodone", 64'(seen), 64'd0);
    chk("flush_result", 64'(result), 64'(last_exp));

    // Start during CALC is ignored, not queued
    ref_op(OP_MUL, 32'd1234, 32'd5678, er, eill, elat);
    issue(OP_MUL, 32'd1234, 32'd5678);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    funct3 = OP_DIVU;
    operand_a = 32'd77;
    operand_b = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    elat = 0;
    for (int c = 6; c <= 40; c++) begin
      if (done) begin
        elat = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("ignore_latency", 64'(elat), 64'd33);
    chk("ignore_result", 64'(result), 64'(er));
    @(posedge clk);
    #1;
    chk("ignore_noqueue", 64'({busy, done}), 64'd0);

    // Reset mid-operation clears everything
    issue(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset", 64'({busy, stall, done, illegal, result}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Flush alongside start in IDLE suppresses the start
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    funct3 = OP_MUL;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    chk("flush_start", 64'(busy), 64'd0);

    // Held start: ignored in DONE, accepted again in the next IDLE
    @(negedge clk);
    start = 1'b1;
    funct3 = OP_DIV;
    operand_a = 32'd5;
    operand_b = 32'd0;
    pat = '0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      pat = {pat[2:0], done};
    end
    start = 1'b0;
    chk("held_start_done", 64'(pat), 64'b1010);
    chk("held_start_res", 64'(result), DE ? 64'hFFFF_FFFF : 64'd0);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      ref_op(f, a, b, er, eill, elat);
      run_op($sformatf("rand%0d_f%0d", i, f), f, a, b, er, eill, elat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
